// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, issue handshake and pending count.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    output logic [AW:0]     pend_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic wr_en_c, wr_hit_iss_c, iss_acc_c, wr_clr_c;
    logic [XLEN-1:0] stored1_c, stored2_c;

    // Writes to x0 are dropped; a same-cycle writeback frees the issuing register.
    assign wr_en_c      = we & (wa != '0);
    assign wr_hit_iss_c = wr_en_c & (wa == iss_rd);
    assign iss_ready    = iss_valid & (~pend_q[iss_rd] | wr_hit_iss_c);
    assign iss_acc_c    = iss_valid & iss_ready & (iss_rd != '0);
    assign wr_clr_c     = wr_en_c & pend_q[wa];

    always_comb begin
        pend_d = pend_q;
        if (wr_en_c) begin
            pend_d[wa] = 1'b0;
        end
        if (iss_acc_c) begin
            pend_d[iss_rd] = 1'b1;
        end
        cnt_d = cnt_q + CW'(iss_acc_c) - CW'(wr_clr_c);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en_c) begin
                regs_q[wa] <= wd;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign stored1_c = (ra1 == '0) ? '0 : regs_q[ra1];
    assign stored2_c = (ra2 == '0) ? '0 : regs_q[ra2];
    assign pend_cnt  = cnt_q;

`ifdef REGFILE_BYPASS_EN
    logic byp1_c, byp2_c;
    assign byp1_c = wr_en_c & (wa == ra1);
    assign byp2_c = wr_en_c & (wa == ra2);
    assign rd1    = byp1_c ? wd : stored1_c;
    assign rd2    = byp2_c ? wd : stored2_c;
    assign busy1  = pend_q[ra1] & ~byp1_c;
    assign busy2  = pend_q[ra2] & ~byp2_c;
`else
    assign rd1    = stored1_c;
    assign rd2    = stored2_c;
    assign busy1  = pend_q[ra1];
    assign busy2  = pend_q[ra2];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default 32x32 instance plus a 64-bit, 16-entry instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int step_n   = 0;

    // ---------------- default instance (XLEN=32, NREGS=32) ----------------
    logic        rst, we, iss_valid, iss_ready, busy1, busy2;
    logic [4:0]  ra1, ra2, wa, iss_rd;
    logic [31:0] wd, rd1, rd2;
    logic [5:0]  pend_cnt;

    regfile_sb dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready), .pend_cnt(pend_cnt)
    );

    // ---------------- wide instance (XLEN=64, NREGS=16) ----------------
    logic        rst2, we2, iv2, rdy2, b1_2, b2_2;
    logic [3:0]  a1_2, a2_2, wa2, ir2;
    logic [63:0] wd2, rd1_2, rd2_2;
    logic [4:0]  cnt2;

    regfile_sb #(.XLEN(64), .NREGS(16)) dut64 (
        .clk(clk), .rst(rst2), .ra1(a1_2), .ra2(a2_2), .rd1(rd1_2), .rd2(rd2_2),
        .busy1(b1_2), .busy2(b2_2), .we(we2), .wa(wa2), .wd(wd2),
        .iss_valid(iv2), .iss_rd(ir2), .iss_ready(rdy2), .pend_cnt(cnt2)
    );

    typedef struct {
        int          step;
        logic [63:0] rd1, rd2;
        logic        b1, b2, rdy;
        logic [63:0] cnt;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    // Behavioural reference: plain arrays, count recomputed as a population count.
    logic [31:0] m_reg  [32];
    bit          m_pend [32];
    logic [63:0] m2_reg [16];
    bit          m2_pend[16];

    task automatic check(input string nm, input int st, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h exp=%h", nm, st, got, exp);
        end
    endtask

    function automatic logic [63:0] read_exp(input int a, input logic [63:0] stored,
                                             input bit w, input int wa_v, input logic [63:0] wd_v);
`ifdef REGFILE_BYPASS_EN
        if (w && wa_v != 0 && wa_v == a) return wd_v;
`endif
        return (a == 0) ? 64'd0 : stored;
    endfunction

    function automatic bit busy_exp(input int a, input bit p, input bit w, input int wa_v);
`ifdef REGFILE_BYPASS_EN
        if (w && wa_v != 0 && wa_v == a) return 1'b0;
`endif
        return (a == 0) ? 1'b0 : p;
    endfunction

    task automatic drive(input bit r, input bit w, input int wa_v, input logic [31:0] wd_v,
                         input bit iv, input int ir, input int a1, input int a2);
        exp_t e;
        int   cnt;
        bit   rdy;
        rst = r; we = w; wa = 5'(wa_v); wd = wd_v;
        iss_valid = iv; iss_rd = 5'(ir); ra1 = 5'(a1); ra2 = 5'(a2);
        cnt = 0;
        foreach (m_pend[i]) cnt += int'(m_pend[i]);
        rdy = iv && (ir == 0 || !m_pend[ir] || (w && wa_v != 0 && wa_v == ir));
        e.step = step_n;
        e.rd1  = read_exp(a1, 64'(m_reg[a1]), w, wa_v, 64'(wd_v));
        e.rd2  = read_exp(a2, 64'(m_reg[a2]), w, wa_v, 64'(wd_v));
        e.b1   = busy_exp(a1, m_pend[a1], w, wa_v);
        e.b2   = busy_exp(a2, m_pend[a2], w, wa_v);
        e.rdy  = rdy;
        e.cnt  = 64'(cnt);
        q1.push_back(e);
        step_n++;
        @(posedge clk);
        if (!r) begin
            foreach (m_reg[i]) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
        end else begin
            if (w && wa_v != 0) begin m_reg[wa_v] = wd_v; m_pend[wa_v] = 1'b0; end
            if (rdy && ir != 0) m_pend[ir] = 1'b1;
        end
        #1;
    endtask

    task automatic drive2(input bit r, input bit w, input int wa_v, input logic [63:0] wd_v,
                          input bit iv, input int ir, input int a1);
        exp_t e;
        int   cnt;
        bit   rdy;
        rst2 = r; we2 = w; wa2 = 4'(wa_v); wd2 = wd_v;
        iv2 = iv; ir2 = 4'(ir); a1_2 = 4'(a1); a2_2 = 4'(a1);
        cnt = 0;
        foreach (m2_pend[i]) cnt += int'(m2_pend[i]);
        rdy = iv && (ir == 0 || !m2_pend[ir] || (w && wa_v != 0 && wa_v == ir));
        e.step = step_n;
        e.rd1  = read_exp(a1, m2_reg[a1], w, wa_v, wd_v);
        e.rd2  = e.rd1;
        e.b1   = busy_exp(a1, m2_pend[a1], w, wa_v);
        e.b2   = e.b1;
        e.rdy  = rdy;
        e.cnt  = 64'(cnt);
        q2.push_back(e);
        step_n++;
        @(posedge clk);
        if (!r) begin
            foreach (m2_reg[i]) begin m2_reg[i] = '0; m2_pend[i] = 1'b0; end
        end else begin
            if (w && wa_v != 0) begin m2_reg[wa_v] = wd_v; m2_pend[wa_v] = 1'b0; end
            if (rdy && ir != 0) m2_pend[ir] = 1'b1;
        end
        #1;
    endtask

    // Monitor: outputs are combinational and always valid, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("rd1",       e.step, 64'(rd1),       e.rd1);
            check("rd2",       e.step, 64'(rd2),       e.rd2);
            check("busy1",     e.step, 64'(busy1),     64'(e.b1));
            check("busy2",     e.step, 64'(busy2),     64'(e.b2));
            check("iss_ready", e.step, 64'(iss_ready), 64'(e.rdy));
            check("pend_cnt",  e.step, 64'(pend_cnt),  e.cnt);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("w64_rd1",       e.step, rd1_2,        e.rd1);
            check("w64_rd2",       e.step, rd2_2,        e.rd2);
            check("w64_busy1",     e.step, 64'(b1_2),    64'(e.b1));
            check("w64_iss_ready", e.step, 64'(rdy2),    64'(e.rdy));
            check("w64_pend_cnt",  e.step, 64'(cnt2),    e.cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog step=%0d got=timeout exp=finish", step_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; iss_valid = 1'b0; iss_rd = '0; ra1 = '0; ra2 = '0;
        rst2 = 1'b0; we2 = 1'b0; wa2 = '0; wd2 = '0; iv2 = 1'b0; ir2 = '0; a1_2 = '0; a2_2 = '0;
        foreach (m_reg[i])  begin m_reg[i]  = '0; m_pend[i]  = 1'b0; end
        foreach (m2_reg[i]) begin m2_reg[i] = '0; m2_pend[i] = 1'b0; end
        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b1;

        // Fill with ones, then reset with simultaneous write and issue.
        for (int i = 1; i < 32; i++) drive(1, 1, i, 32'hFFFF_FFFF, 0, 0, i, 0);
        drive(0, 1, 5, 32'h1111_1111, 1, 9, 1, 2);
        for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0, i, i + 16);

        // x0 is never written nor pending.
        drive(1, 1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // Issue, blocked re-issue, writeback.
        drive(1, 0, 0, 0, 1, 5, 5, 0);
        drive(1, 0, 0, 0, 1, 5, 5, 5);
        drive(1, 1, 5, 32'h1234, 0, 0, 6, 0);
        drive(1, 0, 0, 0, 0, 0, 5, 5);

        // Same-cycle writeback and issue to a pending register.
        drive(1, 0, 0, 0, 1, 7, 7, 0);
        drive(1, 1, 7, 32'hA5, 1, 7, 7, 0);
        drive(1, 0, 0, 0, 0, 0, 7, 7);

        // Same-cycle read of the written register; writeback to a non-pending register.
        drive(1, 1, 3, 32'h55, 0, 0, 3, 3);
        drive(1, 0, 0, 0, 0, 0, 3, 0);

        // Random traffic with collisions on low registers and occasional reset.
        for (int n = 0; n < 1500; n++) begin
            int a[4];
            foreach (a[k]) a[k] = ($urandom % 2 != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
            drive($urandom_range(0, 63) != 0, $urandom % 2 != 0, a[0], $urandom,
                  $urandom % 3 != 0, a[1], a[2], a[3]);
        end

        // Wide instance: fill, pend all 15, blocked issue, reset mid-sequence, ordinary write after.
        for (int i = 1; i < 16; i++) drive2(1, 1, i, {$urandom, $urandom} | 64'd1, 0, 0, i);
        for (int i = 1; i < 16; i++) drive2(1, 0, 0, 0, 1, i, i);
        drive2(1, 0, 0, 0, 1, 3, 3);
        drive2(0, 1, 2, 64'hCAFE, 1, 0, 2);
        for (int i = 0; i < 16; i++) drive2(1, 0, 0, 0, 0, 0, i);
        drive2(1, 1, 4, 64'h77, 0, 0, 4);
        drive2(1, 0, 0, 0, 0, 0, 4);

        repeat (2) @(negedge clk);
        #1;
        check("drain_q1", step_n, 64'(q1.size()), 64'd0);
        check("drain_q2", step_n, 64'(q2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
